// File: rtl/data_mem_ctrl_if.sv
// Request/response bus of the data memory controller.
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; the response is a single-cycle rsp_valid strobe one
// cycle later with no back-pressure; rsp_rdata/rsp_err are 0 when rsp_valid is 0.
interface data_mem_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port data memory controller. After reset it clears the array one
// word per cycle (INIT), then serves one request per cycle (RUN) with a
// registered response one cycle after acceptance. Out-of-range addresses
// return rsp_err and never touch memory.
// Optional feature macro: DMEM_BYTE_WRITE_EN (per-byte write enables via req_be).
module data_mem_ctrl #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    data_mem_ctrl_if.slave   bus,
    output logic             init_done,
    output logic             dbg_state
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                ready_q, ready_d;
    logic                init_done_q, init_done_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [IDX_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_wmask;
    logic [DATA_W-1:0]   be_mask;

    logic                accept;
    logic                in_range;
    logic [IDX_W-1:0]    req_idx;

    assign accept   = bus.req_valid & ready_q;
    // Full-width unsigned compare so high address bits can never alias.
    assign in_range = ({1'b0, bus.req_addr} < DEPTH_EXT);
    assign req_idx  = bus.req_addr[IDX_W-1:0];

`ifdef DMEM_BYTE_WRITE_EN
    // Expand byte enables into a bit mask for the write merge.
    always_comb begin
        be_mask = '0;
        for (int i = 0; i < DATA_W / 8; i++) begin
            be_mask[8*i +: 8] = {8{bus.req_be[i]}};
        end
    end
`else
    logic unused_be;
    assign unused_be = ^bus.req_be;
    assign be_mask   = '1;
`endif

    // Next-state, memory write port and response computation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ready_d     = ready_q;
        init_done_d = init_done_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = idx_q;
        mem_wdata   = '0;
        mem_wmask   = '1;
        case (state_q)
            ST_INIT: begin
                mem_we = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    idx_d       = '0;
                    ready_d     = 1'b1;
                    init_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    rsp_valid_d = 1'b1;
                    if (!in_range) begin
                        rsp_err_d = 1'b1;
                    end else if (bus.req_write) begin
                        mem_we    = 1'b1;
                        mem_waddr = req_idx;
                        mem_wdata = bus.req_wdata;
                        mem_wmask = be_mask;
                    end else begin
                        rsp_rdata_d = mem[req_idx];
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Control and response registers; reset restarts the clear sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            idx_q       <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Memory array: no reset, cleared only by INIT; masked read-modify-write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign init_done     = init_done_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (DATA_W=16, DEPTH=64, ADDR_W=16).
module tb_data_mem_ctrl;
    logic clk;
    logic rst_n;
    logic init_done;
    logic dbg_state;
    int   checks;
    int   failures;
    int   cnt;

    data_mem_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    data_mem_ctrl #(.DATA_W(16), .DEPTH(64), .ADDR_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .init_done (init_done),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive a request at a falling edge, then check the
    // response visible at the next falling edge (one cycle after acceptance).
    task automatic step(input logic v, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic [1:0] be,
                        input logic [15:0] exp_rd, input logic exp_err, input string tag);
        chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_be    = be;
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, bus.rsp_valid}, {31'd0, v});
        chk({tag, "_rdata"}, {16'd0, bus.rsp_rdata}, {16'd0, exp_rd});
        chk({tag, "_err"},   {31'd0, bus.rsp_err},   {31'd0, exp_err});
        bus.req_valid = 1'b0;
    endtask

    // Wait for init_done with requests held active; none may be answered.
    task automatic wait_init(input string tag);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'd6;
        bus.req_wdata = 16'h9999;
        bus.req_be    = 2'b11;
        cnt = 0;
        while (cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (bus.rsp_valid !== 1'b0 || (init_done !== 1'b1 && bus.req_ready !== 1'b0)) begin
                chk({tag, "_quiet_during_init"}, {30'd0, bus.rsp_valid, bus.req_ready}, 32'd0);
            end
            if (init_done === 1'b1) break;
        end
        bus.req_valid = 1'b0;
        chk({tag, "_init_cycles_le65"}, {31'd0, (cnt <= 65)}, 32'd1);
        chk({tag, "_init_cycles_ge64"}, {31'd0, (cnt >= 64)}, 32'd1);
        chk({tag, "_ready_after_init"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready",     {31'd0, bus.req_ready}, 32'd0);
        chk("rst_init_done", {31'd0, init_done},     32'd0);
        chk("rst_valid",     {31'd0, bus.rsp_valid}, 32'd0);
        rst_n = 1'b1;
        wait_init("init1");

        // Every word reads back 0 after the clear (write during INIT was ignored)
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b0, 16'(i), 16'h0, 2'b00, 16'h0, 1'b0, $sformatf("clr_rd%0d", i));
        end
        step(1'b0, 1'b0, 16'd0, 16'h0, 2'b00, 16'h0, 1'b0, "idle0");

        // Write then immediate read
        step(1'b1, 1'b1, 16'd5,  16'h0007, 2'b11, 16'h0, 1'b0, "wr5");
        step(1'b1, 1'b0, 16'd5,  16'h0000, 2'b00, 16'h0007, 1'b0, "rd5");

        // Out-of-range accesses
        step(1'b1, 1'b1, 16'd36,   16'h5A5A, 2'b11, 16'h0, 1'b0, "wr36");
        step(1'b1, 1'b0, 16'd64,   16'h0000, 2'b00, 16'h0, 1'b1, "rd64_err");
        step(1'b1, 1'b1, 16'd100,  16'hFFFF, 2'b11, 16'h0, 1'b1, "wr100_err");
        step(1'b1, 1'b1, 16'hFFC5, 16'h1111, 2'b11, 16'h0, 1'b1, "wr_alias_err");
        step(1'b1, 1'b0, 16'hFFFF, 16'h0000, 2'b00, 16'h0, 1'b1, "rd_max_err");
        step(1'b1, 1'b0, 16'd36,   16'h0000, 2'b00, 16'h5A5A, 1'b0, "rd36_kept");
        step(1'b1, 1'b0, 16'd5,    16'h0000, 2'b00, 16'h0007, 1'b0, "rd5_no_alias");
        step(1'b1, 1'b0, 16'd63,   16'h0000, 2'b00, 16'h0000, 1'b0, "rd63_last");

        // Byte-lane writes
        step(1'b1, 1'b1, 16'd12, 16'h1234, 2'b11, 16'h0, 1'b0, "wr12_full");
        step(1'b1, 1'b1, 16'd12, 16'hABCD, 2'b01, 16'h0, 1'b0, "wr12_be01");
`ifdef DMEM_BYTE_WRITE_EN
        step(1'b1, 1'b0, 16'd12, 16'h0000, 2'b00, 16'h12CD, 1'b0, "rd12_be01");
        step(1'b1, 1'b1, 16'd12, 16'hFFFF, 2'b00, 16'h0, 1'b0, "wr12_be00");
        step(1'b1, 1'b0, 16'd12, 16'h0000, 2'b00, 16'h12CD, 1'b0, "rd12_be00");
`else
        step(1'b1, 1'b0, 16'd12, 16'h0000, 2'b00, 16'hABCD, 1'b0, "rd12_be01");
        step(1'b1, 1'b1, 16'd12, 16'hFFFF, 2'b00, 16'h0, 1'b0, "wr12_be00");
        step(1'b1, 1'b0, 16'd12, 16'h0000, 2'b00, 16'hFFFF, 1'b0, "rd12_be00");
`endif

        // Ten back-to-back mixed requests
        step(1'b1, 1'b1, 16'd20, 16'h0101, 2'b11, 16'h0,    1'b0, "b2b0");
        step(1'b1, 1'b0, 16'd20, 16'h0000, 2'b00, 16'h0101, 1'b0, "b2b1");
        step(1'b1, 1'b1, 16'd21, 16'h0202, 2'b11, 16'h0,    1'b0, "b2b2");
        step(1'b1, 1'b0, 16'd21, 16'h0000, 2'b00, 16'h0202, 1'b0, "b2b3");
        step(1'b1, 1'b1, 16'd20, 16'h0303, 2'b11, 16'h0,    1'b0, "b2b4");
        step(1'b1, 1'b0, 16'd20, 16'h0000, 2'b00, 16'h0303, 1'b0, "b2b5");
        step(1'b1, 1'b0, 16'd21, 16'h0000, 2'b00, 16'h0202, 1'b0, "b2b6");
        step(1'b1, 1'b0, 16'd0,  16'h0000, 2'b00, 16'h0000, 1'b0, "b2b7");
        step(1'b1, 1'b1, 16'd22, 16'h0404, 2'b11, 16'h0,    1'b0, "b2b8");
        step(1'b1, 1'b0, 16'd22, 16'h0000, 2'b00, 16'h0404, 1'b0, "b2b9");
        step(1'b0, 1'b0, 16'd0,  16'h0000, 2'b00, 16'h0000, 1'b0, "b2b_idle");

        // Reset while a read response of addr 6 is being presented
        step(1'b1, 1'b1, 16'd6, 16'h6666, 2'b11, 16'h0, 1'b0, "wr6");
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'd6;
        @(posedge clk);
        #1;
        chk("rd6_pre_rst_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("rd6_pre_rst_rdata", {16'd0, bus.rsp_rdata}, 32'h6666);
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_mid_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
        chk("rst_mid_err",   {31'd0, bus.rsp_err},   32'd0);
        chk("rst_mid_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_mid_done",  {31'd0, init_done},     32'd0);
        repeat (2) @(negedge clk);
        chk("rst_mid_no_stray", {31'd0, bus.rsp_valid}, 32'd0);
        rst_n = 1'b1;

        // Reset again at INIT index 30
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'd6;
        bus.req_wdata = 16'h9999;
        repeat (30) @(negedge clk);
        chk("init30_done",  {31'd0, init_done},     32'd0);
        chk("init30_state", {31'd0, dbg_state},     32'd0);
        rst_n = 1'b0;
        #1;
        chk("init30_rst_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("init30_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init2");
        chk("run_state", {31'd0, dbg_state}, 32'd1);
        step(1'b1, 1'b0, 16'd6,  16'h0, 2'b00, 16'h0, 1'b0, "rd6_post_init");
        step(1'b1, 1'b0, 16'd20, 16'h0, 2'b00, 16'h0, 1'b0, "rd20_post_init");
        step(1'b0, 1'b0, 16'd0,  16'h0, 2'b00, 16'h0, 1'b0, "final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits; multiple of 8.
REQ-002 Parameter DEPTH, default 64, number of words; at least 2.
REQ-003 Parameter ADDR_W, default 16, request address width in word units.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  request present this cycle.
REQ-007 req_ready  output  1  block accepts a request this cycle.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_W  word address.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 req_be  input  DATA_W/8  byte-lane write enables.
REQ-012 rsp_valid  output  1  response strobe, one cycle per accepted request.
REQ-013 rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-014 rsp_err  output  1  accepted request addressed a word at or beyond DEPTH.
REQ-015 init_done  output  1  memory clear complete; block operational.

Function
REQ-016 FSM states: INIT (sequential clear) and RUN; reset enters INIT.
REQ-017 INIT: one word per cycle written to 0, index 0 to DEPTH-1; req_ready = 0; requests ignored.
REQ-018 INIT to RUN on the edge that clears word DEPTH-1; init_done = 1 and req_ready = 1 from the following cycle.
REQ-019 RUN: req_ready held at 1; handshake accepts when req_valid and req_ready are both 1 on a rising edge.
REQ-020 Accepted write with in-range address updates the word on the accepting edge.
REQ-021 Accepted read with in-range address samples the word on the accepting edge.
REQ-022 Latency: rsp_valid = 1 exactly one cycle after acceptance, for reads and writes; no response back-pressure.
REQ-023 Back-to-back requests accepted every cycle; a read immediately following a write to the same address returns the new data.
REQ-024 Address >= DEPTH (unsigned): no memory change; rsp_err = 1, rsp_rdata = 0 in the response cycle.
REQ-025 rsp_rdata and rsp_err are 0 whenever rsp_valid = 0.
REQ-026 Address compared at full ADDR_W width; no wrap-around or aliasing.

Reset
REQ-027 Asserting rst_n low at any time, including mid-INIT or mid-traffic, immediately forces rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, init_done = 0, req_ready = 0, and resets the clear index to 0.
REQ-028 A pending response is discarded on reset; after release, the full INIT clear reruns (DEPTH cycles) before any request is accepted.
REQ-029 Memory array contents are not reset asynchronously; only the INIT sequence clears them.

Configuration
REQ-030 Macro DMEM_BYTE_WRITE_EN defined: a write updates only the byte lanes whose req_be bit is 1; other lanes keep their value; req_be = 0 leaves the word unchanged but still returns a response.
REQ-031 Macro DMEM_BYTE_WRITE_EN undefined: req_be is ignored, every write updates the full word, and the port remains present.

Verification
REQ-032 Release reset with DEPTH=64 -> init_done rises 65 cycles after release at most; reading every address returns 0 with rsp_err = 0.
REQ-033 Write 0x0007 to addr 5, then read addr 5 in the next cycle -> read response rsp_rdata = 0x0007, exactly one cycle after the read is accepted.
REQ-034 Read addr 64 (DEPTH=64) and write 0xFFFF to addr 100 -> both responses have rsp_err = 1 and rsp_rdata = 0; a read of addr 36 still returns its prior value.
REQ-035 With DMEM_BYTE_WRITE_EN, addr 12 holds 0x1234; write 0xABCD with req_be = 2'b01 -> read returns 0x12CD; without the macro -> read returns 0xABCD.
REQ-036 Assert rst_n low during INIT index 30 and again during a read of addr 6 -> rsp_valid drops immediately with no stray response; INIT restarts from index 0; the post-init read of addr 6 returns 0.
REQ-037 Issue 10 consecutive requests (mixed reads and writes) with req_valid held high -> 10 responses on 10 consecutive cycles, each lagging its request by one cycle.
